// File: rtl/sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sb_pkg
//  Purpose : Shared sizing, types and constants for the register scoreboard.
//            Provides the default register-address and pending-counter widths,
//            the matching typedefs and the saturation limit of a counter.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package sb_pkg;

  localparam int SB_ADDRESS_WIDTH = 5;
  localparam int SB_CNT_WIDTH     = 2;

  typedef logic [SB_ADDRESS_WIDTH-1:0] reg_addr_t;
  typedef logic [SB_CNT_WIDTH-1:0]     sb_cnt_t;

  localparam sb_cnt_t SB_CNT_MAX = '1;

endpackage : sb_pkg
`default_nettype wire

// File: rtl/sb_counter.sv
`default_nettype none
// ============================================================================
//  Module  : sb_counter
//  Purpose : Pending-write counter for one architectural register.
//            inc and dec together cancel. A dec with the counter at zero is
//            dropped and reported through underflow_pulse. clr wins over both.
//  Ports   : clk, rst          clock, synchronous active-high reset
//            inc               one more write in flight
//            dec               one write retired
//            clr               discard all in-flight writes
//            cnt               current pending count
//            nonzero           cnt != 0
//            underflow_pulse   dec seen while cnt == 0 (and not cleared)
//  Rev     : 1.0  initial release
// ============================================================================
module sb_counter
  import sb_pkg::*;
#(
  parameter int CNT_WIDTH = SB_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 nonzero,
  output logic                 underflow_pulse
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_zero;
  logic                 w_dec_ok;

  assign w_zero   = (r_cnt == '0);
  // A retire only counts when something is actually outstanding.
  assign w_dec_ok = dec & ~w_zero;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (inc && !w_dec_ok) begin
      // Never at MAX here: the issue-side stall blocks that increment.
      r_cnt <= r_cnt + 1'b1;
    end else if (!inc && w_dec_ok) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign cnt             = r_cnt;
  assign nonzero         = ~w_zero;
  assign underflow_pulse = dec & w_zero & ~clr;

endmodule : sb_counter
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module  : reg_scoreboard
//  Purpose : Tracks in-flight register-file writes between decode and
//            writeback and stalls issue on pending sources or an
//            over-subscribed destination. Register x0 is never tracked.
//  Ports   : clk, rst                 clock, synchronous active-high reset
//            issue_valid              decode presents an instruction
//            issue_rs1/rs2            source registers
//            issue_use_rs1/rs2        instruction reads rs1/rs2
//            issue_we, issue_rd       instruction writes rd
//            retire_valid, retire_rd  writeback register-file write
//            flush                    discard all in-flight tracking
//            stall                    issue not accepted (combinational)
//            busy                     bit i = register i has writes pending
//            err_underflow            sticky: retire with nothing pending
//  Rev     : 1.0  initial release
// ============================================================================
module reg_scoreboard
  import sb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = SB_ADDRESS_WIDTH,
  parameter int CNT_WIDTH     = SB_CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  input  logic [ADDRESS_WIDTH-1:0]    issue_rs1,
  input  logic [ADDRESS_WIDTH-1:0]    issue_rs2,
  input  logic                        issue_use_rs1,
  input  logic                        issue_use_rs2,
  input  logic                        issue_we,
  input  logic [ADDRESS_WIDTH-1:0]    issue_rd,
  input  logic                        retire_valid,
  input  logic [ADDRESS_WIDTH-1:0]    retire_rd,
  input  logic                        flush,
  output logic                        stall,
  output logic [2**ADDRESS_WIDTH-1:0] busy,
  output logic                        err_underflow
);

  localparam int                   NUM_REGS  = 2**ADDRESS_WIDTH;
  localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

  logic [CNT_WIDTH-1:0] w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0]  w_nz;
  logic [NUM_REGS-1:0]  w_inc;
  logic [NUM_REGS-1:0]  w_dec;
  logic [NUM_REGS-1:0]  w_uf;
  logic                 w_rs1_hit;
  logic                 w_rs2_hit;
  logic                 w_rd_full;
  logic                 w_accept;
  logic                 r_err;

  // Stall looks at the registered counts only; a retire in this cycle does
  // not release a dependent issue until the following cycle.
  assign w_rs1_hit = issue_use_rs1 & (issue_rs1 != '0) & w_nz[issue_rs1];
  assign w_rs2_hit = issue_use_rs2 & (issue_rs2 != '0) & w_nz[issue_rs2];
  assign w_rd_full = issue_we & (issue_rd != '0) & (w_cnt[issue_rd] == c_cnt_max);

  assign stall    = issue_valid & (w_rs1_hit | w_rs2_hit | w_rd_full);
  assign w_accept = issue_valid & ~stall & ~flush;

  // x0 has no counter: constant zero, never busy, never underflows.
  assign w_cnt[0] = '0;
  assign w_nz[0]  = 1'b0;
  assign w_inc[0] = 1'b0;
  assign w_dec[0] = 1'b0;
  assign w_uf[0]  = 1'b0;

  generate
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
      // Retire is gated by flush here so a flushed cycle cannot raise an error.
      assign w_inc[i] = w_accept & issue_we & (issue_rd == ADDRESS_WIDTH'(i));
      assign w_dec[i] = retire_valid & ~flush & (retire_rd == ADDRESS_WIDTH'(i));

      sb_counter #(
        .CNT_WIDTH (CNT_WIDTH)
      ) u_cnt (
        .clk             (clk),
        .rst             (rst),
        .inc             (w_inc[i]),
        .dec             (w_dec[i]),
        .clr             (flush),
        .cnt             (w_cnt[i]),
        .nonzero         (w_nz[i]),
        .underflow_pulse (w_uf[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (|w_uf) begin
      r_err <= 1'b1;
    end
  end

  assign busy          = w_nz;
  assign err_underflow = r_err;

endmodule : reg_scoreboard
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_reg_scoreboard
//  Purpose : Self-checking bench for reg_scoreboard: directed scenarios plus
//            randomized traffic checked against an array-of-counts model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_reg_scoreboard;

  localparam int AW   = 5;
  localparam int NR   = 32;
  localparam int MAXC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [AW-1:0] issue_rs1;
  logic [AW-1:0] issue_rs2;
  logic          issue_use_rs1;
  logic          issue_use_rs2;
  logic          issue_we;
  logic [AW-1:0] issue_rd;
  logic          retire_valid;
  logic [AW-1:0] retire_rd;
  logic          flush;
  logic          stall;
  logic [NR-1:0] busy;
  logic          err_underflow;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: number of outstanding writes per register, sticky error.
  int m_cnt [NR];
  bit m_err;

  reg_scoreboard #(.ADDRESS_WIDTH(AW), .CNT_WIDTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_use_rs1 (issue_use_rs1),
    .issue_use_rs2 (issue_use_rs2),
    .issue_we      (issue_we),
    .issue_rd      (issue_rd),
    .retire_valid  (retire_valid),
    .retire_rd     (retire_rd),
    .flush         (flush),
    .stall         (stall),
    .busy          (busy),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  function automatic bit model_stall();
    bit s1, s2, sd;
    s1 = issue_use_rs1 && (issue_rs1 != 0) && (m_cnt[issue_rs1] > 0);
    s2 = issue_use_rs2 && (issue_rs2 != 0) && (m_cnt[issue_rs2] > 0);
    sd = issue_we && (issue_rd != 0) && (m_cnt[issue_rd] == MAXC);
    return issue_valid && (s1 || s2 || sd);
  endfunction

  function automatic logic [NR-1:0] model_busy();
    logic [NR-1:0] b;
    for (int i = 0; i < NR; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  task automatic model_update();
    bit acc;
    bit dec;
    if (rst) begin
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
      m_err = 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    end else begin
      acc = issue_valid && !model_stall();
      dec = 1'b0;
      if (retire_valid && retire_rd != 0) begin
        if (m_cnt[retire_rd] == 0) m_err = 1'b1;
        else dec = 1'b1;
      end
      if (dec) m_cnt[retire_rd] = m_cnt[retire_rd] - 1;
      if (acc && issue_we && issue_rd != 0) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
    end
  endtask

  task automatic idle();
    rst = 0; issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0;
    issue_use_rs1 = 0; issue_use_rs2 = 0; issue_we = 0; issue_rd = 0;
    retire_valid = 0; retire_rd = 0; flush = 0;
  endtask

  task automatic issue(input bit u1, input int rs1, input bit u2, input int rs2,
                       input bit we, input int rd);
    issue_valid = 1; issue_use_rs1 = u1; issue_rs1 = AW'(rs1);
    issue_use_rs2 = u2; issue_rs2 = AW'(rs2); issue_we = we; issue_rd = AW'(rd);
  endtask

  task automatic retire(input int rd);
    retire_valid = 1; retire_rd = AW'(rd);
  endtask

  // Clock edge: the model consumes the same inputs the DUT samples; returns
  // at the following falling edge, where inputs are changed and outputs read.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); idle();
  endtask

  task automatic test_reset();
    rst = 1; flush = 1; issue(1, 3, 0, 0, 1, 3); retire(6);
    tick(); idle(); #1;
    n_checks++; if (busy !== '0) begin n_errors++; $display("FAIL reset_busy got %h exp 0", busy); end
    n_checks++; if (err_underflow !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b exp 0", err_underflow); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got %b exp 0", stall); end
  endtask

  task automatic test_raw();
    do_reset();
    issue(0, 0, 0, 0, 1, 5); #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL raw_first_stall got %b exp 0", stall); end
    tick(); idle();
    issue(1, 5, 0, 0, 0, 0); #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL raw_dep_stall got %b exp 1", stall); end
    n_checks++; if (busy[5] !== 1'b1) begin n_errors++; $display("FAIL raw_busy5 got %b exp 1", busy[5]); end
    tick();
    retire(5); #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL raw_no_bypass got %b exp 1", stall); end
    tick(); retire_valid = 0; #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL raw_release got %b exp 0", stall); end
    n_checks++; if (busy[5] !== 1'b0) begin n_errors++; $display("FAIL raw_busy5_clear got %b exp 0", busy[5]); end
    tick(); idle();
  endtask

  task automatic test_max();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      issue(0, 0, 0, 0, 1, 7); #1;
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL max_fill%0d got %b exp 0", k, stall); end
      tick();
    end
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL max_fourth_stall got %b exp 1", stall); end
    retire(7); #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL max_retire_same_cycle got %b exp 1", stall); end
    tick(); retire_valid = 0; #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL max_fourth_accept got %b exp 0", stall); end
    tick(); idle(); #1;
    issue(0, 0, 0, 0, 1, 7); #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL max_refull got %b exp 1", stall); end
    idle();
  endtask

  task automatic test_same_cycle();
    do_reset();
    issue(0, 0, 0, 0, 1, 9); tick(); idle();
    issue(0, 0, 0, 0, 1, 9); retire(9); tick(); idle(); #1;
    n_checks++; if (busy[9] !== 1'b1) begin n_errors++; $display("FAIL same_busy9 got %b exp 1", busy[9]); end
    retire(9); tick(); idle(); #1;
    n_checks++; if (busy[9] !== 1'b0) begin n_errors++; $display("FAIL same_count_one got %b exp 0", busy[9]); end
    n_checks++; if (err_underflow !== 1'b0) begin n_errors++; $display("FAIL same_err got %b exp 0", err_underflow); end
  endtask

  task automatic test_x0();
    do_reset();
    issue(1, 0, 1, 0, 1, 0); retire(0); #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL x0_stall got %b exp 0", stall); end
    tick(); idle(); #1;
    n_checks++; if (busy !== '0) begin n_errors++; $display("FAIL x0_busy got %h exp 0", busy); end
    n_checks++; if (err_underflow !== 1'b0) begin n_errors++; $display("FAIL x0_err got %b exp 0", err_underflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    retire(12); tick(); idle(); #1;
    n_checks++; if (busy[12] !== 1'b0) begin n_errors++; $display("FAIL uf_busy12 got %b exp 0", busy[12]); end
    n_checks++; if (err_underflow !== 1'b1) begin n_errors++; $display("FAIL uf_set got %b exp 1", err_underflow); end
    tick(); #1;
    n_checks++; if (err_underflow !== 1'b1) begin n_errors++; $display("FAIL uf_sticky got %b exp 1", err_underflow); end
    flush = 1; tick(); idle(); #1;
    n_checks++; if (err_underflow !== 1'b1) begin n_errors++; $display("FAIL uf_after_flush got %b exp 1", err_underflow); end
    rst = 1; tick(); idle(); #1;
    n_checks++; if (err_underflow !== 1'b0) begin n_errors++; $display("FAIL uf_rst_clear got %b exp 0", err_underflow); end
  endtask

  task automatic test_flush_rst();
    logic [NR-1:0] exp_b;
    do_reset();
    issue(0, 0, 0, 0, 1, 3); tick();
    issue(0, 0, 0, 0, 1, 3); tick();
    issue(0, 0, 0, 0, 1, 4); tick(); idle(); #1;
    exp_b = '0; exp_b[3] = 1'b1; exp_b[4] = 1'b1;
    n_checks++; if (busy !== exp_b) begin n_errors++; $display("FAIL fl_prefill got %h exp %h", busy, exp_b); end
    flush = 1; issue(0, 0, 0, 0, 1, 3); retire(4); tick(); idle(); #1;
    n_checks++; if (busy !== '0) begin n_errors++; $display("FAIL fl_clear got %h exp 0", busy); end
    n_checks++; if (err_underflow !== 1'b0) begin n_errors++; $display("FAIL fl_no_err got %b exp 0", err_underflow); end
    issue(0, 0, 0, 0, 1, 8); tick(); idle();
    issue(0, 0, 0, 0, 1, 10); retire(12); rst = 1; tick(); idle(); #1;
    n_checks++; if (busy !== '0) begin n_errors++; $display("FAIL rst_mid_busy got %h exp 0", busy); end
    n_checks++; if (err_underflow !== 1'b0) begin n_errors++; $display("FAIL rst_mid_err got %b exp 0", err_underflow); end
  endtask

  task automatic test_random();
    bit exp_s;
    int pick;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      idle();
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) != 0)
        issue($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
              $urandom_range(0, 7), $urandom_range(0, 2) != 0, $urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) begin
        pick = $urandom_range(0, 7);
        // Mostly retire something outstanding; occasionally a stray retire.
        for (int k = 0; k < 8; k++)
          if (m_cnt[(pick + k) % 8] != 0 && $urandom_range(0, 9) != 0) begin
            pick = (pick + k) % 8;
            break;
          end
        retire(pick);
      end
      #1;
      exp_s = model_stall();
      n_checks++; if (stall !== exp_s) begin n_errors++; $display("FAIL rnd_stall c=%0d got %b exp %b", c, stall, exp_s); end
      tick();
      n_checks++; if (busy !== model_busy()) begin n_errors++; $display("FAIL rnd_busy c=%0d got %h exp %h", c, busy, model_busy()); end
      n_checks++; if (err_underflow !== m_err) begin n_errors++; $display("FAIL rnd_err c=%0d got %b exp %b", c, err_underflow, m_err); end
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    m_err = 1'b0;
    idle();
    @(negedge clk);
    test_reset();
    test_raw();
    test_max();
    test_same_cycle();
    test_x0();
    test_underflow();
    test_flush_rst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_reg_scoreboard
`default_nettype wire
